// File: rtl/io_ctrl.sv
// Memory-mapped board I/O: keys (sync + debounce + sticky press flags), switches, LEDs, 7-seg.
// Latency: reads return one cycle after re, writes visible next cycle; backpressure: none, one access per cycle.
module io_ctrl #(
  parameter int unsigned       DBITS           = 32,
  parameter int unsigned       KEY_BITS        = 4,
  parameter int unsigned       SW_BITS         = 10,
  parameter int unsigned       LEDR_BITS       = 10,
  parameter int unsigned       LEDG_BITS       = 8,
  parameter int unsigned       HEX_DIGITS      = 4,
  parameter logic [15:0]       DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [DBITS-1:0]  ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0]  ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0]  ADDR_LEDG       = 32'hF0000008,
  parameter logic [DBITS-1:0]  ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KSTAT      = 32'hF0000110
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        addr,
  input  logic                    we,
  input  logic [DBITS-1:0]        wdata,
  input  logic                    re,
  output logic [DBITS-1:0]        rdata,
  output logic                    rvalid,
  input  logic [KEY_BITS-1:0]     KEY,
  input  logic [SW_BITS-1:0]      SW,
  output logic [LEDR_BITS-1:0]    LEDR,
  output logic [LEDG_BITS-1:0]    LEDG,
  output logic [7*HEX_DIGITS-1:0] HEX
);

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [KEY_BITS-1:0]     key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [KEY_BITS-1:0]     key_acc_q, key_acc_d, key_acc_dly_q, key_acc_dly_d;
  logic [15:0]             cnt_q [KEY_BITS];
  logic [15:0]             cnt_d [KEY_BITS];
  logic [SW_BITS-1:0]      sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [KEY_BITS-1:0]     kstat_q, kstat_d;
  logic [DBITS-1:0]        hex_reg_q, hex_reg_d;
  logic [7*HEX_DIGITS-1:0] hex_seg_q, hex_seg_d;
  logic [LEDR_BITS-1:0]    ledr_q, ledr_d;
  logic [LEDG_BITS-1:0]    ledg_q, ledg_d;
  logic [DBITS-1:0]        rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;

  logic [DBITS-3:0]        word;
  logic                    hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw, hit_kstat;
  logic [KEY_BITS-1:0]     press, w1c;
  logic [DBITS-1:0]        rd_val;
  logic                    addr_unused;

  assign addr_unused = ^addr[1:0];
  assign word      = addr[DBITS-1:2];
  assign hit_hex   = (word == ADDR_HEX[DBITS-1:2]);
  assign hit_ledr  = (word == ADDR_LEDR[DBITS-1:2]);
  assign hit_ledg  = (word == ADDR_LEDG[DBITS-1:2]);
  assign hit_key   = (word == ADDR_KEY[DBITS-1:2]);
  assign hit_sw    = (word == ADDR_SW[DBITS-1:2]);
  assign hit_kstat = (word == ADDR_KSTAT[DBITS-1:2]);

  always_comb begin
    key_s1_d = KEY;
    key_s2_d = key_s1_q;
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;

    // Counter tracks consecutive cycles the synced level disagrees with the accepted one.
    key_acc_d = key_acc_q;
    for (int i = 0; i < KEY_BITS; i++) begin
      cnt_d[i] = '0;
      if (key_s2_q[i] != key_acc_q[i]) begin
        if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
          key_acc_d[i] = key_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
    key_acc_dly_d = key_acc_q;

    press   = key_acc_dly_q & ~key_acc_q;
    w1c     = (we && hit_kstat) ? wdata[KEY_BITS-1:0] : '0;
    kstat_d = (kstat_q & ~w1c) | press;

    hex_reg_d = (we && hit_hex)  ? wdata                 : hex_reg_q;
    ledr_d    = (we && hit_ledr) ? wdata[LEDR_BITS-1:0]  : ledr_q;
    ledg_d    = (we && hit_ledg) ? wdata[LEDG_BITS-1:0]  : ledg_q;
    for (int i = 0; i < HEX_DIGITS; i++) begin
      hex_seg_d[7*i +: 7] = seg7(hex_reg_d[4*i +: 4]);
    end

    // Read mux sees pre-write state, so a same-cycle write is not observed.
    rd_val = '0;
    if (hit_hex)   rd_val = hex_reg_q;
    if (hit_ledr)  rd_val[LEDR_BITS-1:0] = ledr_q;
    if (hit_ledg)  rd_val[LEDG_BITS-1:0] = ledg_q;
    if (hit_key)   rd_val[KEY_BITS-1:0]  = ~key_acc_q;
    if (hit_sw)    rd_val[SW_BITS-1:0]   = sw_s2_q;
    if (hit_kstat) rd_val[KEY_BITS-1:0]  = kstat_q;
    rdata_d  = re ? rd_val : rdata_q;
    rvalid_d = re;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_s1_q      <= '1;
      key_s2_q      <= '1;
      key_acc_q     <= '1;
      key_acc_dly_q <= '1;
      for (int i = 0; i < KEY_BITS; i++) cnt_q[i] <= '0;
      sw_s1_q       <= '1;
      sw_s2_q       <= '1;
      kstat_q       <= '0;
      hex_reg_q     <= '0;
      hex_seg_q     <= {HEX_DIGITS{7'b1000000}};
      ledr_q        <= '0;
      ledg_q        <= '0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
    end else begin
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      key_acc_q     <= key_acc_d;
      key_acc_dly_q <= key_acc_dly_d;
      for (int i = 0; i < KEY_BITS; i++) cnt_q[i] <= cnt_d[i];
      sw_s1_q       <= sw_s1_d;
      sw_s2_q       <= sw_s2_d;
      kstat_q       <= kstat_d;
      hex_reg_q     <= hex_reg_d;
      hex_seg_q     <= hex_seg_d;
      ledr_q        <= ledr_d;
      ledg_q        <= ledg_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign LEDR   = ledr_q;
  assign LEDG   = ledg_q;
  assign HEX    = hex_seg_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model built from the register-map rules.
module tb_io_ctrl;
  localparam int DEB = 4;
  localparam logic [31:0] A_HEX = 32'hF0000000, A_LEDR = 32'hF0000004, A_LEDG = 32'hF0000008,
                          A_KEY = 32'hF0000010, A_SW = 32'hF0000014, A_KSTAT = 32'hF0000110;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, rvalid;
  logic [3:0]  KEY;
  logic [9:0]  SW, LEDR;
  logic [7:0]  LEDG;
  logic [27:0] HEX;

  int n_chk = 0;
  int n_pass = 0;

  io_ctrl #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata), .re(re),
    .rdata(rdata), .rvalid(rvalid), .KEY(KEY), .SW(SW),
    .LEDR(LEDR), .LEDG(LEDG), .HEX(HEX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Lit segments of each hex glyph; display is active-low with segment a in bit 0.
  string seg_lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [27:0] hex_of(input logic [31:0] v);
    logic [27:0] r;
    logic [6:0]  m;
    string       s;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      m = 7'h7F;
      s = seg_lit[v[4*d +: 4]];
      for (int j = 0; j < s.len(); j++) begin
        int idx;
        idx = int'(s[j]) - 97;
        m[idx] = 1'b0;
      end
      r[7*d +: 7] = m;
    end
    return r;
  endfunction

  // Behavioural model: updated on each rising edge from the inputs the DUT sees.
  logic [3:0]  m_k1, m_k2, m_acc, m_acc_old, m_press, m_w1c;
  logic [3:0]  m_hist [$];
  logic [9:0]  m_sw1, m_sw2, m_ledr;
  logic [7:0]  m_ledg;
  logic [31:0] m_hex, m_rdata, m_rd, m_a;
  logic [3:0]  m_kstat;
  logic        m_rvalid;
  bit          m_ok = 0;
  bit          m_all;

  always @(posedge clk) begin
    if (!reset) begin
      m_k1 = '1; m_k2 = '1; m_acc = '1; m_press = '0;
      m_hist.delete();
      m_sw1 = '1; m_sw2 = '1;
      m_hex = '0; m_ledr = '0; m_ledg = '0; m_kstat = '0;
      m_rdata = '0; m_rvalid = 1'b0;
      m_ok = 1;
    end else if (m_ok) begin
      m_a  = {addr[31:2], 2'b00};
      m_rd = 32'd0;
      case (m_a)
        A_HEX:   m_rd = m_hex;
        A_LEDR:  m_rd = {22'd0, m_ledr};
        A_LEDG:  m_rd = {24'd0, m_ledg};
        A_KEY:   m_rd = {28'd0, ~m_acc};
        A_SW:    m_rd = {22'd0, m_sw2};
        A_KSTAT: m_rd = {28'd0, m_kstat};
        default: m_rd = 32'd0;
      endcase
      m_rvalid = re;
      if (re) m_rdata = m_rd;

      m_w1c   = (we && m_a == A_KSTAT) ? wdata[3:0] : 4'd0;
      m_kstat = (m_kstat & ~m_w1c) | m_press;
      if (we && m_a == A_HEX)  m_hex  = wdata;
      if (we && m_a == A_LEDR) m_ledr = wdata[9:0];
      if (we && m_a == A_LEDG) m_ledg = wdata[7:0];

      // Accept a new level once the last DEB synchronised samples all disagree with it.
      m_hist.push_back(m_k2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      m_acc_old = m_acc;
      if (m_hist.size() == DEB) begin
        for (int k = 0; k < 4; k++) begin
          m_all = 1;
          foreach (m_hist[j]) if (m_hist[j][k] == m_acc_old[k]) m_all = 0;
          if (m_all) m_acc[k] = ~m_acc_old[k];
        end
      end
      m_press = m_acc_old & ~m_acc;

      m_k2 = m_k1; m_k1 = KEY;
      m_sw2 = m_sw1; m_sw1 = SW;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("rvalid", {63'd0, rvalid}, {63'd0, m_rvalid});
      if (m_rvalid) chk("rdata", {32'd0, rdata}, {32'd0, m_rdata});
      chk("ledr", {54'd0, LEDR}, {54'd0, m_ledr});
      chk("ledg", {56'd0, LEDG}, {56'd0, m_ledg});
      chk("hex", {36'd0, HEX}, {36'd0, hex_of(m_hex)});
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk({name, "_rvalid"}, {63'd0, rvalid}, 64'd1);
    chk(name, {32'd0, rdata}, {32'd0, exp});
  endtask

  logic [31:0] addrs [8] = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_SW, A_KSTAT, 32'hF0000020, 32'h00001000};

  initial begin
    reset = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; KEY = '1; SW = '0;
    repeat (3) @(negedge clk);
    chk("rst_hex", {36'd0, HEX}, {36'd0, {4{7'b1000000}}});
    chk("rst_ledr", {54'd0, LEDR}, 64'd0);
    chk("rst_ledg", {56'd0, LEDG}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    do_write(A_HEX, 32'h0000BEEF);
    chk("hex_beef", {36'd0, HEX}, {36'd0, 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});
    do_read("rd_hex", A_HEX, 32'h0000BEEF);

    KEY[1] = 1'b0; repeat (3) @(negedge clk); KEY[1] = 1'b1;
    repeat (10) @(negedge clk);
    do_read("kstat_short", A_KSTAT, 32'h0);
    KEY[1] = 1'b0; repeat (6) @(negedge clk); KEY[1] = 1'b1;
    repeat (10) @(negedge clk);
    do_read("kstat_long", A_KSTAT, 32'h2);
    chk("model_kstat", {60'd0, m_kstat}, 64'h2);

    KEY[0] = 1'b0; repeat (6) @(negedge clk); KEY[0] = 1'b1;
    repeat (12) @(negedge clk);
    do_read("kstat_both", A_KSTAT, 32'h3);
    do_read("kstat_noclr", A_KSTAT, 32'h3);
    do_write(A_KSTAT, 32'h1);
    do_read("kstat_w1c", A_KSTAT, 32'h2);
    KEY[0] = 1'b0; repeat (6) @(negedge clk);
    KEY[0] = 1'b1;
    do_write(A_KSTAT, 32'h3);
    do_read("kstat_setwins", A_KSTAT, 32'h1);
    repeat (12) @(negedge clk);

    SW = 10'h2A5;
    repeat (3) @(negedge clk);
    do_read("rd_sw", A_SW, 32'h2A5);
    do_write(A_SW, 32'h0);
    do_read("rd_sw_nowr", A_SW, 32'h2A5);
    do_read("rd_sw_lowbits", 32'hF0000016, 32'h2A5);
    do_read("rd_key_idle", A_KEY, 32'h0);
    do_read("rd_unmapped", 32'hF0000020, 32'h0);

    do_write(A_LEDR, 32'h155);
    addr = A_LEDR; wdata = 32'h0AA; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk("rw_same_old", {32'd0, rdata}, 64'h155);
    chk("rw_same_led", {54'd0, LEDR}, 64'h0AA);

    do_write(A_LEDR, 32'h3FF);
    chk("ledr_3ff", {54'd0, LEDR}, 64'h3FF);
    reset = 1'b0;
    @(negedge clk);
    chk("ledr_reset", {54'd0, LEDR}, 64'h0);
    reset = 1'b1;
    addr = A_LEDR; re = 1'b1; reset = 1'b0;
    @(negedge clk);
    re = 1'b0; reset = 1'b1;
    chk("read_during_reset", {63'd0, rvalid}, 64'd0);
    repeat (2) @(negedge clk);

    for (int c = 0; c < 4000; c++) begin
      we    = ($urandom_range(0, 3) == 0);
      re    = ($urandom_range(0, 2) == 0);
      addr  = addrs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) KEY[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) SW = 10'($urandom);
      reset = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0; reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
